// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one synchronous-read mmu port among REQUESTERS
// masters, one transaction at a time, with an optional ownership lock.
module mem_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int IDX_W      = $clog2(REQUESTERS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REQUESTERS-1:0]      req,
  input  logic [REQUESTERS-1:0]      lock,
  input  logic [REQUESTERS-1:0]      we,
  input  logic [REQUESTERS*32-1:0]   addr,
  input  logic [REQUESTERS*32-1:0]   wd,
  input  logic [REQUESTERS*2-1:0]    rd_unit,
  input  logic [REQUESTERS*2-1:0]    wd_unit,
  output logic [REQUESTERS-1:0]      gnt,
  output logic [REQUESTERS-1:0]      rvalid,
  output logic [31:0]                rdata,
  output logic [1:0]                 rfault,
  output logic [IDX_W-1:0]           owner,
  output logic                       mem_re,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wd,
  output logic [1:0]                 mem_rd_unit,
  output logic [1:0]                 mem_wd_unit,
  input  logic [31:0]                mem_rd,
  input  logic                       access_fault,
  input  logic                       addr_misaligned
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQUESTERS - 1);

  function automatic logic [REQUESTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REQUESTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [31:0] addr_a    [REQUESTERS];
  logic [31:0] wd_a      [REQUESTERS];
  logic [1:0]  rd_unit_a [REQUESTERS];
  logic [1:0]  wd_unit_a [REQUESTERS];

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_unpack
    assign addr_a[g]    = addr[32*g +: 32];
    assign wd_a[g]      = wd[32*g +: 32];
    assign rd_unit_a[g] = rd_unit[2*g +: 2];
    assign wd_unit_a[g] = wd_unit[2*g +: 2];
  end

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    we_l_q, we_l_d;
  logic [1:0]              fault_l_q, fault_l_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [1:0]              rfault_q, rfault_d;
  logic [REQUESTERS-1:0]   gnt_q, gnt_d;
  logic [REQUESTERS-1:0]   rvalid_q, rvalid_d;
  logic                    mem_re_q, mem_re_d;
  logic                    mem_we_q, mem_we_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wd_q, mem_wd_d;
  logic [1:0]              mem_rd_unit_q, mem_rd_unit_d;
  logic [1:0]              mem_wd_unit_q, mem_wd_unit_d;

  logic                    win_found_s;
  logic [IDX_W-1:0]        win_idx_s;
  logic                    lock_hit_s;
  logic                    pick_found_s;
  logic [IDX_W-1:0]        pick_idx_s;

  // Round-robin search: first requester at or after rr_ptr, wrapping at REQUESTERS.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             take;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand        = IDX_W'((int'(rr_ptr_q) + i) % REQUESTERS);
      take        = !win_found_s && req[cand];
      win_idx_s   = take ? cand : win_idx_s;
      win_found_s = win_found_s | req[cand];
    end
  end

  // A locked owner re-requesting from RESP keeps the port regardless of rr_ptr.
  assign lock_hit_s   = (state_q == RESP) && req[owner_q] && lock[owner_q];
  assign pick_found_s = lock_hit_s | win_found_s;
  assign pick_idx_s   = lock_hit_s ? owner_q : win_idx_s;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    we_l_d        = we_l_q;
    fault_l_d     = fault_l_q;
    rdata_d       = rdata_q;
    rfault_d      = rfault_q;
    gnt_d         = '0;
    rvalid_d      = '0;
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = 32'h0000_0000;
    mem_wd_d      = 32'h0000_0000;
    mem_rd_unit_d = 2'b00;
    mem_wd_unit_d = 2'b00;
    case (state_q)
      IDLE, RESP: begin
        if (pick_found_s) begin
          state_d       = ISSUE;
          owner_d       = pick_idx_s;
          we_l_d        = we[pick_idx_s];
          gnt_d         = onehot(pick_idx_s);
          mem_re_d      = ~we[pick_idx_s];
          mem_we_d      = we[pick_idx_s];
          mem_addr_d    = addr_a[pick_idx_s];
          mem_wd_d      = wd_a[pick_idx_s];
          mem_rd_unit_d = rd_unit_a[pick_idx_s];
          mem_wd_unit_d = wd_unit_a[pick_idx_s];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        fault_l_d = {access_fault, addr_misaligned};
        rr_ptr_d  = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
        state_d   = WAIT;
      end
      WAIT: begin
        // Writes and faulted accesses return zero data.
        rdata_d  = (we_l_q || (fault_l_q != 2'b00)) ? 32'h0000_0000 : mem_rd;
        rfault_d = fault_l_q;
        rvalid_d = onehot(owner_q);
        state_d  = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      we_l_q        <= 1'b0;
      fault_l_q     <= 2'b00;
      rdata_q       <= 32'h0000_0000;
      rfault_q      <= 2'b00;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0000_0000;
      mem_wd_q      <= 32'h0000_0000;
      mem_rd_unit_q <= 2'b00;
      mem_wd_unit_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      we_l_q        <= we_l_d;
      fault_l_q     <= fault_l_d;
      rdata_q       <= rdata_d;
      rfault_q      <= rfault_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wd_q      <= mem_wd_d;
      mem_rd_unit_q <= mem_rd_unit_d;
      mem_wd_unit_q <= mem_wd_unit_d;
    end
  end

  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign rfault      = rfault_q;
  assign owner       = owner_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wd      = mem_wd_q;
  assign mem_rd_unit = mem_rd_unit_q;
  assign mem_wd_unit = mem_wd_unit_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected grants and
// responses; a negedge monitor pops and compares them against the DUT.
module tb_mem_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N-1:0]     req, lock, we;
  logic [N*32-1:0]  addr, wd;
  logic [N*2-1:0]   rd_unit, wd_unit;
  logic [N-1:0]     gnt, rvalid;
  logic [31:0]      rdata;
  logic [1:0]       rfault;
  logic [0:0]       owner;
  logic             mem_re, mem_we;
  logic [31:0]      mem_addr, mem_wd;
  logic [1:0]       mem_rd_unit, mem_wd_unit;
  logic [31:0]      mem_rd = 32'h0;
  logic             access_fault, addr_misaligned;

  mem_arbiter #(.REQUESTERS(N)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wd(wd), .rd_unit(rd_unit), .wd_unit(wd_unit),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rfault(rfault), .owner(owner),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd_unit(mem_rd_unit), .mem_wd_unit(mem_wd_unit), .mem_rd(mem_rd),
    .access_fault(access_fault), .addr_misaligned(addr_misaligned)
  );

  // Small mmu: rom at 0x8000_0xxx, ram at 0x4000_0xxx, everything else unmapped.
  logic [31:0] rom [16];
  logic [31:0] ram [16];
  logic        in_rom, in_ram;
  logic [1:0]  unit;
  assign in_rom          = (mem_addr[31:12] == 20'h80000);
  assign in_ram          = (mem_addr[31:12] == 20'h40000);
  assign access_fault    = !(in_rom || in_ram);
  assign unit            = mem_we ? mem_wd_unit : mem_rd_unit;
  assign addr_misaligned = ((unit == 2'd2) && (mem_addr[1:0] != 2'b00)) ||
                           ((unit == 2'd1) && mem_addr[0]);

  always @(posedge clk) begin
    if (mem_re)
      mem_rd <= (access_fault || addr_misaligned) ? 32'hBAD0_BAD0 :
                in_rom ? rom[mem_addr[5:2]] : ram[mem_addr[5:2]];
    if (mem_we && !access_fault && !addr_misaligned)
      ram[mem_addr[5:2]] <= mem_wd;
  end

  typedef struct {
    int          m;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  u;
    logic [31:0] rd;
    logic [1:0]  flt;
  } exp_t;

  exp_t exp_g[$];
  exp_t exp_r[$];
  int   lat_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] onehot(input int m);
    logic [N-1:0] v;
    v    = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every grant and response against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("gnt_rvalid_excl", 32'(gnt & rvalid), 32'h0);
      if (gnt != '0) begin
        if (exp_g.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt), 32'h0);
        end else begin
          e = exp_g.pop_front();
          chk("gnt_onehot", 32'(gnt), 32'(onehot(e.m)));
          chk("owner", 32'(owner), 32'(e.m));
          chk("mem_re", 32'(mem_re), 32'(!e.w));
          chk("mem_we", 32'(mem_we), 32'(e.w));
          chk("mem_addr", mem_addr, e.a);
          chk("mem_wd", mem_wd, e.d);
          chk("mem_units", 32'({mem_rd_unit, mem_wd_unit}), 32'({e.u, e.u}));
          lat_q.push_back(cyc);
        end
      end else begin
        chk("mem_idle", 32'({mem_re, mem_we, mem_rd_unit, mem_wd_unit}) | mem_addr | mem_wd,
            32'h0);
      end
      if (rvalid != '0) begin
        if (exp_r.size() == 0) begin
          chk("unexpected_rvalid", 32'(rvalid), 32'h0);
        end else begin
          e = exp_r.pop_front();
          chk("rvalid_onehot", 32'(rvalid), 32'(onehot(e.m)));
          chk("rdata", rdata, e.rd);
          chk("rfault", 32'(rfault), 32'(e.flt));
          if (lat_q.size() != 0) chk("rvalid_latency", cyc, lat_q.pop_front() + 2);
          else chk("rvalid_without_gnt", 32'h1, 32'h0);
        end
      end
    end
  end

  task automatic set_cmd(input int m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] u, input logic lk);
    req[m]              = 1'b1;
    lock[m]             = lk;
    we[m]               = w;
    addr[m*32 +: 32]    = a;
    wd[m*32 +: 32]      = d;
    rd_unit[m*2 +: 2]   = u;
    wd_unit[m*2 +: 2]   = u;
  endtask

  task automatic push_exp(input int m, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] u,
                          input logic [31:0] rd, input logic [1:0] flt);
    exp_t e;
    e.m = m; e.w = w; e.a = a; e.d = d; e.u = u; e.rd = rd; e.flt = flt;
    exp_g.push_back(e);
    exp_r.push_back(e);
  endtask

  task automatic wait_gnt(input int m, output int c);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt[m] !== 1'b1 && k < 30);
    chk($sformatf("gnt%0d_seen", m), 32'(gnt[m]), 32'h1);
    c = cyc;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_r.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", exp_r.size(), 32'h0);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_gnt_rvalid"}, 32'({gnt, rvalid}), 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_rfault_owner"}, 32'({rfault, owner}), 32'h0);
    chk({tag, "_mem_ctl"}, 32'({mem_re, mem_we, mem_rd_unit, mem_wd_unit}), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wd"}, mem_wd, 32'h0);
  endtask

  // Asserts reset between clock edges and checks outputs clear without a clock.
  task automatic apply_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_outputs_zero(tag);
    exp_g.delete();
    exp_r.delete();
    lat_q.delete();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    int c0, c1, c2, n, k, seen;
    int gc [8];
    for (int i = 0; i < 16; i++) begin
      rom[i] = 32'h1000_0000 + i;
      ram[i] = 32'h0;
    end
    rom[1] = 32'hDEAD_BEEF;
    reset = 1'b1; req = '0; lock = '0; we = '0;
    addr = '0; wd = '0; rd_unit = '0; wd_unit = '0;
    #1 reset = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Single read from rom.
    @(negedge clk);
    c0 = cyc;
    set_cmd(0, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0);
    push_exp(0, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 32'hDEAD_BEEF, 2'b00);
    wait_gnt(0, c1);
    chk("single_gnt_latency", c1, c0 + 1);
    req[0] = 1'b0;
    drain();

    // Write then back-to-back read by master 1.
    set_cmd(1, 1'b1, 32'h4000_0010, 32'h1234_5678, 2'd2, 1'b0);
    push_exp(1, 1'b1, 32'h4000_0010, 32'h1234_5678, 2'd2, 32'h0, 2'b00);
    wait_gnt(1, c1);
    set_cmd(1, 1'b0, 32'h4000_0010, 32'h0, 2'd2, 1'b0);
    push_exp(1, 1'b0, 32'h4000_0010, 32'h0, 2'd2, 32'h1234_5678, 2'b00);
    wait_gnt(1, c2);
    chk("wr_rd_issue_spacing", c2 - c1, 32'd3);
    req[1] = 1'b0;
    drain();

    // Faults: unmapped address, then misaligned word read.
    set_cmd(0, 1'b0, 32'h9000_0000, 32'h0, 2'd2, 1'b0);
    push_exp(0, 1'b0, 32'h9000_0000, 32'h0, 2'd2, 32'h0, 2'b10);
    wait_gnt(0, c1);
    req[0] = 1'b0;
    drain();
    set_cmd(0, 1'b0, 32'h4000_0002, 32'h0, 2'd2, 1'b0);
    push_exp(0, 1'b0, 32'h4000_0002, 32'h0, 2'd2, 32'h0, 2'b01);
    wait_gnt(0, c1);
    req[0] = 1'b0;
    drain();

    // Fairness: both masters request continuously after reset.
    apply_reset("fair_reset");
    @(negedge clk);
    set_cmd(0, 1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0);
    set_cmd(1, 1'b0, 32'h8000_000C, 32'h0, 2'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_exp(0, 1'b0, 32'h8000_0008, 32'h0, 2'd2, 32'h1000_0002, 2'b00);
      else            push_exp(1, 1'b0, 32'h8000_000C, 32'h0, 2'd2, 32'h1000_0003, 2'b00);
    end
    n = 0; k = 0;
    while (n < 6 && k < 60) begin
      @(negedge clk);
      k++;
      if (gnt != '0) begin
        gc[n] = cyc;
        n++;
      end
    end
    req = '0;
    chk("fair_grant_count", n, 32'd6);
    for (int i = 1; i < n; i++) chk("fair_gnt_spacing", gc[i] - gc[i-1], 32'd3);
    drain();

    // Lock: master 0 keeps ownership for three accesses while master 1 waits.
    set_cmd(0, 1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b1);
    set_cmd(1, 1'b0, 32'h8000_0014, 32'h0, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++)
      push_exp(0, 1'b0, 32'h8000_0010, 32'h0, 2'd2, 32'h1000_0004, 2'b00);
    push_exp(1, 1'b0, 32'h8000_0014, 32'h0, 2'd2, 32'h1000_0005, 2'b00);
    n = 0; k = 0;
    while (n < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (gnt != '0) begin
        gc[n] = cyc;
        n++;
      end
    end
    lock[0] = 1'b0;
    req[0]  = 1'b0;
    chk("lock_grant_count", n, 32'd3);
    wait_gnt(1, c1);
    chk("lock_release_spacing", c1 - gc[2], 32'd3);
    req[1] = 1'b0;
    drain();

    // Reset while a read is in WAIT: dropped, and master 0 regains priority.
    set_cmd(0, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0);
    push_exp(0, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 32'hDEAD_BEEF, 2'b00);
    wait_gnt(0, c1);
    req[0] = 1'b0;
    @(negedge clk);
    apply_reset("mid_reset");
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid != '0) seen++;
    end
    chk("no_rvalid_after_reset", seen, 32'd0);
    set_cmd(0, 1'b0, 32'h8000_0018, 32'h0, 2'd2, 1'b0);
    set_cmd(1, 1'b0, 32'h8000_001C, 32'h0, 2'd2, 1'b0);
    push_exp(0, 1'b0, 32'h8000_0018, 32'h0, 2'd2, 32'h1000_0006, 2'b00);
    push_exp(1, 1'b0, 32'h8000_001C, 32'h0, 2'd2, 32'h1000_0007, 2'b00);
    wait_gnt(0, c1);
    req[0] = 1'b0;
    wait_gnt(1, c2);
    req[1] = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single CPU-side mmu port (re/we/addr/wd/rd_unit/wd_unit/rd plus fault flags) between REQUESTERS bus masters, e.g. core and a DMA/debug master.
- Round-robin arbitration with an optional lock for back-to-back ownership.
- Runs one transaction at a time.
- Accounts for the one-cycle synchronous read latency of rom/ram/led_mmap behind the mmu.

Parameters:
- REQUESTERS, 2, number of masters (2..8)
- IDX_W, $clog2(REQUESTERS), owner index width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  REQUESTERS  per-master request; held until gnt
- lock  in  REQUESTERS  keep ownership for the next request
- we  in  REQUESTERS  1 = write, 0 = read
- addr  in  REQUESTERS*32  byte address, master i at [32i+:32]
- wd  in  REQUESTERS*32  write data
- rd_unit  in  REQUESTERS*2  read size code, passed through
- wd_unit  in  REQUESTERS*2  write size code, passed through
- gnt  out  REQUESTERS  one-hot, one-cycle pulse: command accepted
- rvalid  out  REQUESTERS  one-hot, one-cycle pulse: response valid
- rdata  out  32  read data, valid with rvalid
- rfault  out  2  {access_fault, addr_misaligned}, valid with rvalid
- owner  out  IDX_W  index of current/last owner
- mem_re, mem_we  out  1  to mmu
- mem_addr, mem_wd  out  32  to mmu
- mem_rd_unit, mem_wd_unit  out  2  to mmu
- mem_rd  in  32  from mmu; valid the cycle after mem_re
- access_fault, addr_misaligned  in  1  from mmu; combinational with current mem_addr

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (async, reset=0):
  - state=IDLE; gnt, rvalid, mem_re, mem_we = 0.
  - mem_addr, mem_wd, rdata = 0; mem_*_unit = 0; rfault = 0; owner = 0.
  - rr_ptr=0, so master 0 has top priority.
  - A transaction in flight is dropped with no rvalid; the master re-requests.
- All outputs are registered. mem_* are driven from a latched command register and are 0 outside ISSUE.
- IDLE:
  - At each edge, if any req: pick winner w = first set req scanning rr_ptr, rr_ptr+1, ... modulo REQUESTERS.
  - Latch w's we/addr/wd/units; owner<=w; next=ISSUE.
- ISSUE (1 cycle):
  - gnt[owner]=1.
  - mem_re = ~we_l, mem_we = we_l, remaining mem_* = latched values.
  - At end of cycle, latch access_fault/addr_misaligned; rr_ptr <= owner+1 (mod REQUESTERS); next=WAIT.
- WAIT (1 cycle): mem_* = 0. At end of cycle, rdata <= mem_rd for reads, 0 for writes; next=RESP.
- RESP (1 cycle):
  - rvalid[owner]=1 with rdata/rfault; writes also get rvalid (write ack).
  - Arbitration runs as in IDLE, with one override: if req[owner] && lock[owner], owner wins regardless of rr_ptr.
  - If a winner exists, next=ISSUE, else IDLE.
- Throughput: one transaction per 3 cycles back-to-back. Latency: req seen at edge E → gnt in cycle E+1 → rvalid in cycle E+3.
- Masters:
  - Must hold req and command stable until gnt.
  - Must drop req the cycle after gnt unless issuing a new request.
  - A master still holding req from a previous command when the arbiter samples in RESP is treated as a new request.
  - req is ignored in ISSUE and WAIT.
- Faults:
  - Command is still issued to the mmu (the mmu suppresses the device strobe).
  - rdata = 0 on fault; rfault reports the flags; the arbiter does not retry.
- Non-power-of-2 REQUESTERS: rr_ptr wraps to 0 after REQUESTERS-1.
- lock on a master that is not the current owner has no effect.
- gnt and rvalid are never both asserted in the same cycle.

Test Plan:
- Single read:
  - Stimulus: master 0 reads 0x8000_0004, rd_unit=2, rom word 0xDEADBEEF.
  - Required: gnt[0] at +1; mem_re=1 and mem_addr=0x8000_0004 in that cycle only; rvalid[0] at +3 with rdata=0xDEADBEEF, rfault=0.
- Write then read:
  - Stimulus: master 1 writes 0x1234_5678 to 0x4000_0010, then reads it back.
  - Required: mem_we pulses once; write rvalid with rdata=0; second ISSUE exactly 3 cycles after the first; read returns 0x1234_5678.
- Fairness:
  - Stimulus: both masters hold req continuously for 6 transactions after reset.
  - Required: grant order 0,1,0,1,0,1; no gnt gap beyond 2 cycles.
- Lock:
  - Stimulus: master 0 holds lock=1 and req for 3 accesses while master 1 requests.
  - Required: master 0 gets 3 consecutive grants, then master 1 is granted next once lock drops.
- Fault:
  - Stimulus: read of 0x9000_0000 (unmapped); then read of 0x4000_0002 with rd_unit=word.
  - Required: first rvalid with rfault=2'b10, rdata=0; second with rfault=2'b01.
- Reset mid-transaction:
  - Stimulus: assert reset=0 during WAIT.
  - Required: all outputs 0 immediately without waiting for a clock; no rvalid after release; the next request is serviced normally with master 0 having priority.
